uart_receiver: RTL and testbench

Standalone UART receive engine for one tapped line: it rebuilds serial frames from the real bus into parallel words for the interception logic. It sits next to the per-interface transmit path and feeds captured bytes upstream through a valid/ack handshake. It provides glitch-filtered start detection, 3-sample majority voting, and framing/overrun reporting. Serial format is 8N1 by default, with optional even parity.

---
 rtl/uart_receiver.sv | 176 +++++++++++++++++
 tb/tb_uart_receiver.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive engine: 2-flop synchronizer, 3-sample majority vote per bit, framing/overrun reporting.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_receiver #(
    parameter int BIT_DURATION  = 104,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     rx_in,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ack,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     overrun,
    output logic                     busy
);

    localparam int M  = BIT_DURATION / 2;
    localparam int CW = $clog2(BIT_DURATION);

    localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(M);
    localparam logic [CW-1:0] CNT_VOTE = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DURATION - 1);
    localparam logic [3:0]    BITS_ALL = 4'(NUM_DATA_BITS);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                   state_q;
    logic                     sync1_q, sync2_q, prev_q;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic [3:0]               bit_cnt_q;
    logic [NUM_DATA_BITS-1:0] shift_q;
    logic                     s0_q, s1_q;
    logic [NUM_DATA_BITS-1:0] rx_data_q;
    logic                     rx_valid_q, overrun_q, frame_err_q, busy_q;
`ifdef UART_RX_PARITY_EN
    logic                     par_bit_q, parity_err_q;
`endif

    logic vote, fall, at_vote, at_last;

    always_comb begin
        vote    = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
        fall    = ~sync2_q & prev_q;
        at_vote = (cnt_q == CNT_VOTE);
        at_last = (cnt_q == CNT_LAST);
        cnt_d   = at_last ? '0 : cnt_q + CW'(1);
    end

    // The line idles high, so the synchronizer resets to 1 to avoid a false start after reset.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // An accepted ack clears the word; a delivery on the same cycle overrides it below.
            if (rx_valid_q && rx_ack) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            cnt_q <= cnt_d;
            if (cnt_q == CNT_S0) s0_q <= sync2_q;
            if (cnt_q == CNT_S1) s1_q <= sync2_q;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (fall) begin
                        state_q   <= START;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (at_vote && vote) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (at_last) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (at_vote) begin
                        shift_q   <= {vote, shift_q[NUM_DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    if (at_last && bit_cnt_q == BITS_ALL) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_vote) par_bit_q <= vote;
                    if (at_last) state_q <= STOP;
                end
`endif
                // Leave at the mid-stop vote so a back-to-back start edge is not missed.
                STOP: begin
                    if (at_vote) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!vote) begin
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if ((^shift_q) ^ par_bit_q) begin
                            parity_err_q <= 1'b1;
`endif
                        end else if (!rx_valid_q || rx_ack) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            overrun_q  <= 1'b0;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed vector table, hand-written corner sequences and a random
// frame stream, all checked against a frame-level reference model with per-cycle comparison.
module tb_uart_receiver;
    localparam int BD = 16;
    localparam int NB = 8;
    localparam int M  = BD / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L     = 3 + (NB + 1 + P) * BD + M + 2;
    localparam int FRAME = (NB + 2 + P) * BD;

    logic          sys_clk = 1'b0;
    logic          rst     = 1'b1;
    logic          rx_in   = 1'b1;
    logic          rx_ack  = 1'b0;
    logic [NB-1:0] rx_data;
    logic          rx_valid, frame_err, parity_err, overrun, busy;

    uart_receiver #(.BIT_DURATION(BD), .NUM_DATA_BITS(NB)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            due;
        logic [NB-1:0] data;
        bit            stop;
        bit            par_ok;
    } frame_t;

    typedef struct {
        logic [NB-1:0] d;
        bit            stop;
        bit            par_ok;
        bit            exp_dlv;
        bit            exp_fe;
        bit            exp_pe;
    } vec_t;

    frame_t        pend[$];
    bit            mv = 1'b0;
    bit            mo = 1'b0;
    logic [NB-1:0] md = '0;
    int            last_rise = -1;
    int            ferr_cnt  = 0;
    int            perr_cnt  = 0;
    bit            abort_tx  = 1'b0;
    bit            rand_done = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each frame resolves at start + L; delivery follows the valid/ack rules.
    initial begin
        bit     ack_e, mf, mp, dlv, v_prev;
        frame_t e;
        v_prev = 1'b0;
        forever begin
            @(posedge sys_clk);
            ack_e = rx_ack;
            @(negedge sys_clk);
            mf  = 1'b0;
            mp  = 1'b0;
            dlv = 1'b0;
            if (!rst) begin
                mv = 1'b0;
                mo = 1'b0;
                md = '0;
                pend.delete();
            end else begin
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    e = pend.pop_front();
                    if (!e.stop) mf = 1'b1;
                    else if (P == 1 && !e.par_ok) mp = 1'b1;
                    else dlv = 1'b1;
                end
                if (dlv && (!mv || ack_e)) begin
                    md = e.data;
                    mv = 1'b1;
                    mo = 1'b0;
                end else if (dlv) begin
                    mo = 1'b1;
                end else if (mv && ack_e) begin
                    mv = 1'b0;
                    mo = 1'b0;
                end
            end
            tests++;
            if ({rx_valid, rx_data, overrun, frame_err, parity_err} !== {mv, md, mo, mf, mp}) begin
                fails++;
                $display("FAIL cycle_model @%0d: dut v=%0b d=%02h ovr=%0b fe=%0b pe=%0b, model v=%0b d=%02h ovr=%0b fe=%0b pe=%0b",
                         cyc, rx_valid, rx_data, overrun, frame_err, parity_err, mv, md, mo, mf, mp);
            end
            if (rx_valid && !v_prev) last_rise = cyc;
            if (frame_err) ferr_cnt++;
            if (parity_err) perr_cnt++;
            v_prev = rx_valid;
        end
    end

    task automatic drive_bit(input logic v, input int n);
        if (abort_tx) begin
            rx_in = 1'b1;
            return;
        end
        rx_in = v;
        repeat (n) begin
            @(negedge sys_clk);
            if (abort_tx) begin
                rx_in = 1'b1;
                return;
            end
        end
    endtask

    // Called just after a negedge; the start bit is driven immediately.
    task automatic send_frame(input logic [NB-1:0] d, input bit stop, input bit par_ok, input int stop_len);
        frame_t e;
        e.due    = cyc + L;
        e.data   = d;
        e.stop   = stop;
        e.par_ok = par_ok;
        pend.push_back(e);
        drive_bit(1'b0, BD);
        for (int i = 0; i < NB; i++) drive_bit(d[i], BD);
        if (P == 1) drive_bit(par_ok ? ^d : ~(^d), BD);
        drive_bit(stop, stop_len);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic ack_once();
        rx_ack = 1'b1;
        @(negedge sys_clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        int   t0, f0, p0;

        vecs.push_back('{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
`endif

        #1 rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset_outputs", {rx_data, rx_valid, frame_err, parity_err, overrun, busy}, 0);
        @(posedge sys_clk);
        #2 rst = 1'b1;
        idle(5);

        // First word: exact latency and single-cycle ack.
        last_rise = -1;
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b1, BD);
        idle(2);
        check("a5_latency", last_rise - t0, L);
        check("a5_data", rx_data, 8'hA5);
        ack_once();
        check("a5_ack_clears_valid", rx_valid, 0);

        // 3-cycle low glitch: START is entered then abandoned silently.
        f0 = ferr_cnt;
        rx_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("glitch_busy_in_start", busy, 1);
        idle(BD);
        check("glitch_back_to_idle", busy, 0);
        check("glitch_no_flags", {rx_valid, overrun, 1'(ferr_cnt != f0)}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            f0 = ferr_cnt;
            p0 = perr_cnt;
            last_rise = -1;
            t0 = cyc;
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].par_ok, BD);
            idle(4);
            check($sformatf("vec%0d_deliver_at_L", i), (last_rise == t0 + L), vecs[i].exp_dlv);
            check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, vecs[i].exp_fe);
            check($sformatf("vec%0d_parity_err", i), perr_cnt - p0, vecs[i].exp_pe);
            if (vecs[i].exp_dlv) check($sformatf("vec%0d_data", i), rx_data, vecs[i].d);
            $display("[TB] vec %0d data=%02h stop=%0b par_ok=%0b -> valid=%0b data=%02h fe=%0d pe=%0d",
                     i, vecs[i].d, vecs[i].stop, vecs[i].par_ok, rx_valid, rx_data, ferr_cnt - f0, perr_cnt - p0);
            if (rx_valid) ack_once();
        end

        // Back-to-back words without ack: second word dropped, overrun set.
        send_frame(8'h01, 1'b1, 1'b1, BD);
        send_frame(8'h02, 1'b1, 1'b1, BD);
        idle(4);
        check("overrun_keeps_first", rx_data, 8'h01);
        check("overrun_flag", {rx_valid, overrun}, 2'b11);
        ack_once();
        check("overrun_ack_clears", {rx_valid, overrun}, 2'b00);

        // Ack landing on the exact delivery cycle of the next word.
        send_frame(8'h11, 1'b1, 1'b1, BD);
        idle(4);
        fork
            send_frame(8'h22, 1'b1, 1'b1, BD);
            begin
                repeat (L - 1) @(negedge sys_clk);
                rx_ack = 1'b1;
                @(negedge sys_clk);
                rx_ack = 1'b0;
                check("ack_on_delivery_data", rx_data, 8'h22);
                check("ack_on_delivery_flags", {rx_valid, overrun}, 2'b10);
            end
        join
        idle(4);
        ack_once();

        // Break: line held low far beyond one frame.
        f0 = ferr_cnt;
        send_frame(8'h00, 1'b0, 1'b1, 4 * BD);
        check("break_one_frame_err", ferr_cnt - f0, 1);
        check("break_idle_while_low", busy, 0);
        idle(BD);
        check("break_no_second_err", ferr_cnt - f0, 1);

        // Reset in the middle of a frame.
        f0 = ferr_cnt;
        fork
            send_frame(8'hC3, 1'b1, 1'b1, BD);
            begin
                repeat (60) @(negedge sys_clk);
                check("midframe_busy", busy, 1);
                @(posedge sys_clk);
                #2 rst = 1'b0;
                abort_tx = 1'b1;
                @(negedge sys_clk);
                check("midframe_reset_outputs", {rx_data, rx_valid, frame_err, parity_err, overrun, busy}, 0);
                repeat (2) @(negedge sys_clk);
                @(posedge sys_clk);
                #2 rst = 1'b1;
            end
        join
        abort_tx = 1'b0;
        idle(2 * FRAME);
        check("midframe_no_delivery", {rx_valid, busy}, 0);
        check("midframe_no_flag", ferr_cnt - f0, 0);

        // Random frames with stop-edge jitter, occasional errors and random acks.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [NB-1:0] d;
                    bit            stp, pok;
                    int            sl;
                    d   = NB'($urandom);
                    stp = ($urandom_range(0, 7) != 0);
                    pok = ($urandom_range(0, 5) != 0);
                    sl  = stp ? (BD - 4 + int'($urandom_range(0, 8))) : BD;
                    send_frame(d, stp, pok, sl);
                    if (!stp) idle(4);
                    else if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 40)));
                end
                idle(2 * BD);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge sys_clk);
                    rx_ack = ($urandom_range(0, 3) == 0);
                end
                rx_ack = 1'b0;
            end
        join
        idle(4);
        check("all_frames_resolved", pend.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
